// File: rtl/axi_mem_wr_ctrl_if.sv
// AXI3 write-channel bundle (AW, W, B) between the framebuffer write
// master and the DDR interconnect.
interface axi_mem_wr_ctrl_if;

    // Write address channel
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [1:0]  AWLOCK;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic [3:0]  AWQOS;
    logic        AWVALID;
    logic        AWREADY;

    // Write data channel
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;

    // Write response channel
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWLOCK, AWSIZE, AWBURST, AWCACHE, AWPROT, AWQOS, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWLOCK, AWSIZE, AWBURST, AWCACHE, AWPROT, AWQOS, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/axi_mem_wr_ctrl.sv
// axi_mem_wr_ctrl: buffers a 24-bit pixel stream in a fall-through FIFO and
// writes it to the DDR framebuffer as fixed 8-beat INCR bursts of 32-bit
// words, one burst outstanding at a time. The write offset wraps at the end
// of the frame and FrameDone pulses when it does.
module axi_mem_wr_ctrl #(
    parameter logic [31:0] FB_BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] FB_MAX_ADDR  = 32'd3686400,
    parameter int          FIFO_DP      = 64,
    parameter logic [3:0]  AXI_ID       = 4'h0
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_mem_wr_ctrl_if.master axi,
    input  logic              PixValid,
    output logic              PixReady,
    input  logic [23:0]       PixData,
    output logic              WrErr,
    output logic              FrameDone
);

    localparam int                PTR_W     = $clog2(FIFO_DP);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DP);
    localparam logic [CNT_W-1:0]  BURST_WDS = CNT_W'(8);
    localparam logic [31:0]       LAST_OFF  = FB_MAX_ADDR - 32'd32;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_AWSU = 4'b0010,
        S_WDAT = 4'b0100,
        S_BRSP = 4'b1000
    } state_t;

    // Pixel FIFO
    logic [23:0]      fifo_mem [FIFO_DP];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             push;
    logic             pop;

    // Control state
    state_t      state;
    state_t      state_nxt;
    logic [31:0] wr_off;
    logic [31:0] wr_off_nxt;
    logic [2:0]  beat_cnt;
    logic [2:0]  beat_cnt_nxt;
    logic [31:0] aw_addr_nxt;
    logic        aw_valid_nxt;
    logic        w_valid_nxt;
    logic        b_ready_nxt;
    logic        wr_err_nxt;
    logic        frame_done_nxt;

    logic        aw_hs;
    logic        b_hs;

    // The response ID is not checked; a single burst is ever outstanding.
    logic        unused_bid;
    assign unused_bid = ^axi.BID;

    assign PixReady = (fifo_cnt != FIFO_FULL);
    assign push     = PixValid & PixReady;
    assign pop      = axi.WVALID & axi.WREADY;
    assign aw_hs    = axi.AWVALID & axi.AWREADY;
    assign b_hs     = axi.BVALID & axi.BREADY;

    // Pixel storage; only written on an accepted pixel.
    // NOTE: the storage array has no reset on purpose -- its contents are
    // only read behind a non-zero count, and leaving it unreset lets it map
    // onto plain RAM.
    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= PixData;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle cancel out.
    // NOTE: every register here uses <= so all of them sample the same
    // pre-edge values, independent of statement order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic for the burst sequencer.
    // NOTE: every signal gets its hold/default value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        aw_valid_nxt   = axi.AWVALID;
        aw_addr_nxt    = axi.AWADDR;
        w_valid_nxt    = axi.WVALID;
        b_ready_nxt    = axi.BREADY;
        wr_err_nxt     = WrErr;
        wr_off_nxt     = wr_off;
        beat_cnt_nxt   = beat_cnt;
        frame_done_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                // Eight words present means the whole burst is reserved:
                // nothing but this sequencer pops the FIFO.
                if (fifo_cnt >= BURST_WDS) begin
                    aw_valid_nxt = 1'b1;
                    aw_addr_nxt  = FB_BASE_ADDR + wr_off;
                    state_nxt    = S_AWSU;
                end
            end

            S_AWSU: begin
                if (aw_hs) begin
                    aw_valid_nxt = 1'b0;
                    w_valid_nxt  = 1'b1;
                    beat_cnt_nxt = 3'd0;
                    state_nxt    = S_WDAT;
                end
            end

            S_WDAT: begin
                if (pop) begin
                    beat_cnt_nxt = beat_cnt + 3'd1;
                    if (beat_cnt == 3'd7) begin
                        w_valid_nxt = 1'b0;
                        b_ready_nxt = 1'b1;
                        state_nxt   = S_BRSP;
                    end
                end
            end

            S_BRSP: begin
                if (b_hs) begin
                    b_ready_nxt = 1'b0;
                    // Error responses are recorded but the burst is not retried.
                    if (axi.BRESP != 2'b00) begin
                        wr_err_nxt = 1'b1;
                    end
                    if (wr_off < LAST_OFF) begin
                        wr_off_nxt = wr_off + 32'd32;
                    end else begin
                        wr_off_nxt     = 32'd0;
                        frame_done_nxt = 1'b1;
                    end
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                aw_valid_nxt = 1'b0;
                w_valid_nxt  = 1'b0;
                b_ready_nxt  = 1'b0;
                state_nxt    = S_IDLE;
            end
        endcase
    end

    // Registered AXI handshake outputs, frame offset and beat counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            axi.AWVALID <= 1'b0;
            axi.AWADDR  <= 32'd0;
            axi.WVALID  <= 1'b0;
            axi.BREADY  <= 1'b0;
            WrErr       <= 1'b0;
            FrameDone   <= 1'b0;
            wr_off      <= 32'd0;
            beat_cnt    <= 3'd0;
        end else begin
            axi.AWVALID <= aw_valid_nxt;
            axi.AWADDR  <= aw_addr_nxt;
            axi.WVALID  <= w_valid_nxt;
            axi.BREADY  <= b_ready_nxt;
            WrErr       <= wr_err_nxt;
            FrameDone   <= frame_done_nxt;
            wr_off      <= wr_off_nxt;
            beat_cnt    <= beat_cnt_nxt;
        end
    end

    // Fixed burst shape: 8 beats of 4 bytes, incrementing, full strobes.
    assign axi.AWID    = AXI_ID;
    assign axi.AWLEN   = 4'h7;
    assign axi.AWLOCK  = 2'h0;
    assign axi.AWSIZE  = 3'h2;
    assign axi.AWBURST = 2'h1;
    assign axi.AWCACHE = 4'h0;
    assign axi.AWPROT  = 3'h1;
    assign axi.AWQOS   = 4'h0;

    // Write data comes straight from the fall-through FIFO head, so a
    // stalled beat (WREADY low) keeps both WDATA and WLAST unchanged.
    assign axi.WID   = AXI_ID;
    assign axi.WDATA = {8'h00, fifo_mem[rd_ptr]};
    assign axi.WSTRB = 4'hF;
    assign axi.WLAST = (beat_cnt == 3'd7) & axi.WVALID;

endmodule
